// File: rtl/integral_box_sum.sv
`default_nettype none
// ============================================================================
// Module   : integral_box_sum
// Purpose  : Converts a raster-order integral-image stream into KxK box sums
//            whose bottom-right corner is the current pixel:
//            S = I(x,y) - I(x-K,y) - I(x,y-K) + I(x-K,y-K), out-of-image = 0.
//            Fixed two-cycle latency, tolerant of gaps in din_valid.
// Revision : 1.0 - initial release
// ============================================================================
module integral_box_sum #(
  parameter int DATA_WIDTH = 28,
  parameter int K          = 8,
  parameter int ROW        = 480,
  parameter int COL        = 640
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic [9:0]            i_col_cnt,
  input  logic [9:0]            i_row_cnt,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [9:0]            o_col_cnt,
  output logic [9:0]            o_row_cnt,
  output logic                  o_win_full
);

  localparam int              c_DEPTH = K * COL;
  localparam int              c_AW    = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
  localparam logic [c_AW-1:0] c_LAST  = c_AW'(c_DEPTH - 1);
  localparam logic [9:0]      c_K     = 10'(K);
  localparam logic [9:0]      c_KM1   = 10'(K - 1);

  // Reject parameter sets the coordinate width or box logic cannot handle.
  if (K < 2 || K > 32 || ROW < 1 || ROW > 1024 || COL < 1 || COL > 1024) begin : g_bad_params
    $error("integral_box_sum: unsupported parameter set");
  end

  // --------------------------------------------------------------------------
  // Row delay: circular line buffer holding the last K rows of the stream.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [c_DEPTH];
  logic [c_AW-1:0]       wp_q;
  logic [c_AW-1:0]       wp_d;
  logic [c_AW-1:0]       w_addr;
  logic                  w_frame_start;
  logic [DATA_WIDTH-1:0] rd_q;           // I(x,y-K), aligned with stage 1

  // Pixel (0,0) always lands on address 0 so the pointer realigns every frame.
  assign w_frame_start = (i_col_cnt == 10'd0) && (i_row_cnt == 10'd0);
  assign w_addr        = w_frame_start ? '0 : wp_q;
  assign wp_d          = (w_addr == c_LAST) ? '0 : w_addr + 1'b1;

  // Line-buffer port: read old contents then overwrite with the new sample.
  always_ff @(posedge clk) begin
    if (din_valid && !rst) begin
      rd_q          <= mem_q[w_addr];
      mem_q[w_addr] <= din;
    end
  end

  // Write pointer advances once per accepted sample and wraps without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
    end else if (din_valid) begin
      wp_q <= wp_d;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: register the current sample, its K-sample-old neighbour and the
  // coordinates; the column shift register on the live stream lives here.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] cur_sr_q [K];
  logic [DATA_WIDTH-1:0] a1_q;           // I(x,y)
  logic [DATA_WIDTH-1:0] b1_q;           // I(x-K,y), unmasked
  logic [9:0]            col1_q;
  logic [9:0]            row1_q;
  logic                  v1_q;

  // Capture stage-1 operands and shift the live stream on each valid sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      col1_q <= '0;
      row1_q <= '0;
      for (int i = 0; i < K; i++) cur_sr_q[i] <= '0;
    end else begin
      v1_q <= din_valid;
      if (din_valid) begin
        a1_q        <= din;
        b1_q        <= cur_sr_q[K-1];
        col1_q      <= i_col_cnt;
        row1_q      <= i_row_cnt;
        cur_sr_q[0] <= din;
        for (int i = 1; i < K; i++) cur_sr_q[i] <= cur_sr_q[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: mask out-of-image corners and combine the four terms. The column
  // shift register on the row-delayed stream is fed from the RAM read data.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] row_sr_q [K];
  logic                  w_left;
  logic                  w_top;
  logic [DATA_WIDTH-1:0] w_b;
  logic [DATA_WIDTH-1:0] w_c;
  logic [DATA_WIDTH-1:0] w_d;
  logic [DATA_WIDTH-1:0] w_sum;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dout_valid_q;
  logic [9:0]            col_q;
  logic [9:0]            row_q;
  logic                  win_q;

  // Coordinate masks keep stale rows/frames out of the result.
  assign w_left = (col1_q < c_K);
  assign w_top  = (row1_q < c_K);
  assign w_b    = w_left           ? '0 : b1_q;
  assign w_c    = w_top            ? '0 : rd_q;
  assign w_d    = (w_left | w_top) ? '0 : row_sr_q[K-1];
  assign w_sum  = a1_q - w_b - w_c + w_d;

  // Register the box sum and its sideband; hold dout across idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= 1'b0;
      for (int i = 0; i < K; i++) row_sr_q[i] <= '0;
    end else begin
      dout_valid_q <= v1_q;
      if (v1_q) begin
        dout_q      <= w_sum;
        col_q       <= col1_q;
        row_q       <= row1_q;
        win_q       <= (col1_q >= c_KM1) && (row1_q >= c_KM1);
        row_sr_q[0] <= rd_q;
        for (int i = 1; i < K; i++) row_sr_q[i] <= row_sr_q[i-1];
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign o_col_cnt  = col_q;
  assign o_row_cnt  = row_q;
  assign o_win_full = win_q;

endmodule
`default_nettype wire

// File: tb/tb_integral_box_sum.sv
`default_nettype none
// ============================================================================
// Module   : tb_integral_box_sum
// Purpose  : Scoreboard bench for integral_box_sum with COL=16, ROW=12, K=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_integral_box_sum;

  localparam int DW = 28;
  localparam int KB = 4;
  localparam int NC = 16;
  localparam int NR = 12;

  logic          clk;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic [9:0]    i_col_cnt;
  logic [9:0]    i_row_cnt;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [9:0]    o_col_cnt;
  logic [9:0]    o_row_cnt;
  logic          o_win_full;

  integral_box_sum #(
    .DATA_WIDTH(DW), .K(KB), .ROW(NR), .COL(NC)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .i_col_cnt(i_col_cnt), .i_row_cnt(i_row_cnt),
    .dout(dout), .dout_valid(dout_valid),
    .o_col_cnt(o_col_cnt), .o_row_cnt(o_row_cnt), .o_win_full(o_win_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  typedef struct {
    logic [DW-1:0] exp;
    int            x;
    int            y;
    logic          win;
    int            cyc;
    int            mode;
  } exp_t;

  exp_t sb[$];

  // Pixel value of each test image: 0 = all ones, 1 = ramp, 2 = all 255.
  function automatic int pix(input int mode, input int x, input int y);
    case (mode)
      0:       return 1;
      1:       return x + 16 * y;
      default: return 255;
    endcase
  endfunction

  function automatic int integ(input int mode, input int x, input int y);
    int s = 0;
    if (x < 0 || y < 0) return 0;
    for (int j = 0; j <= y; j++)
      for (int i = 0; i <= x; i++)
        s += pix(mode, i, j);
    return s;
  endfunction

  task automatic send(input int mode, input int x, input int y, input bit gap);
    exp_t e;
    int   box;
    if (gap) begin
      while ($urandom_range(0, 1) == 0) begin
        din_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    box = integ(mode, x, y) - integ(mode, x - KB, y) - integ(mode, x, y - KB)
        + integ(mode, x - KB, y - KB);
    din       = DW'(integ(mode, x, y));
    din_valid = 1'b1;
    i_col_cnt = 10'(x);
    i_row_cnt = 10'(y);
    e.exp  = DW'(box);
    e.x    = x;
    e.y    = y;
    e.win  = (x >= KB - 1) && (y >= KB - 1);
    e.cyc  = cyc;
    e.mode = mode;
    sb.push_back(e);
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic frame(input int mode, input bit gap);
    for (int y = 0; y < NR; y++)
      for (int x = 0; x < NC; x++)
        send(mode, x, y, gap);
  endtask

  // Compare each produced result against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (dout_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dout", dout, e.exp);
        chk("col", o_col_cnt, e.x);
        chk("row", o_row_cnt, e.y);
        chk("win_full", o_win_full, e.win);
        chk("latency", cyc - e.cyc, 32'd2);
        if (e.mode == 0) begin
          if (e.x == 0  && e.y == 0)  chk("ones_0_0", dout, 32'd1);
          if (e.x == 3  && e.y == 3)  chk("ones_3_3", dout, 32'd16);
          if (e.x == 10 && e.y == 2)  chk("ones_10_2", dout, 32'd12);
          if (e.x == 2  && e.y == 10) chk("ones_2_10", dout, 32'd12);
          if (e.x == 15 && e.y == 11) chk("ones_15_11", dout, 32'd16);
        end
        if (e.mode == 1 && e.x == 15 && e.y == 11) chk("ramp_15_11", dout, 32'd2648);
        if (e.mode == 2 && e.x == 0 && e.y == 0)   chk("w255_0_0", dout, 32'd255);
      end
    end
  end

  initial begin
    int n;
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    i_col_cnt = '0;
    i_row_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", dout, 32'd0);
    chk("rst_valid", dout_valid, 32'd0);
    chk("rst_col", o_col_cnt, 32'd0);
    chk("rst_row", o_row_cnt, 32'd0);
    chk("rst_win", o_win_full, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    frame(0, 1'b0);   // all ones, continuous
    frame(0, 1'b1);   // all ones, random gaps
    frame(1, 1'b0);   // ramp
    frame(2, 1'b0);   // all 255 ...
    frame(0, 1'b0);   // ... immediately followed by all ones

    // Partial frame, then a one-cycle reset right after pixel (7,5).
    for (int y = 0; y < NR; y++)
      for (int x = 0; x < NC; x++)
        if (y * NC + x <= 5 * NC + 7) send(0, x, y, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_flush_valid", dout_valid, 32'd0);
    chk("rst_flush_dout", dout, 32'd0);
    sb.delete();
    @(posedge clk); #1;

    frame(0, 1'b0);   // fresh frame after reset
    frame(1, 1'b1);   // ramp with gaps

    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", sb.size(), 32'd0);
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
